// File: rtl/vs_log_pkg.sv
// Shared offsets, control codes and FSM encoding for the voltage-sequencer log slave.
package vs_log_pkg;

    localparam logic [1:0]  OFF_DATA      = 2'd0;
    localparam logic [1:0]  OFF_LEVEL     = 2'd1;
    localparam logic [1:0]  OFF_DROP      = 2'd2;

    localparam logic [15:0] END_MARK_DFLT = 16'hffff;
    localparam logic [15:0] CTRL_PAUSE    = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RAM_WAIT = 2'd1,
        ST_RESP     = 2'd2
    } vs_state_e;

endpackage

// File: rtl/vs_log_ram.sv
// Simple dual-port sample RAM: synchronous capture write port, registered read port.
module vs_log_ram #(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [15:0]       wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [15:0]       rd_data
);

    logic [15:0] mem_q [0:(1<<ADDR_W)-1];
    logic [15:0] rd_data_q;

    // No reset on the array or read register: contents are undefined until written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/vs_log_wb_slave.sv
// Wishbone slave exposing a circular voltage-sequencer sample log through one indirect data register.
// Build option VS_LOG_STATUS_EN adds the level/dropped status registers and the dropped counter.
//
// state       | meaning
// ST_IDLE     | waiting for a new transaction
// ST_RAM_WAIT | log RAM read in flight for an offset-0 data read
// ST_RESP     | ack or err driven for this single cycle
module vs_log_wb_slave
    import vs_log_pkg::*;
#(
    parameter int unsigned ADDR_W   = 12,
    parameter logic [15:0] END_MARK = END_MARK_DFLT
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [1:0]  wb_adr_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    input  logic        sample_valid,
    input  logic [15:0] sample_data
);

    localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

    vs_state_e         state_q, state_d;
    logic              paused_q, paused_d;
    logic [ADDR_W-1:0] wp_q, wp_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W:0]   rd_idx_q, rd_idx_d;
    logic [ADDR_W-1:0] oldest_q, oldest_d;
    logic              resp_err_q, resp_err_d;
    logic [15:0]       dat_q, dat_d;
`ifdef VS_LOG_STATUS_EN
    logic [15:0]       dropped_q, dropped_d;
`endif

    logic              pending;
    logic              trans;
    logic              wr_ctrl;
    logic              wr_pause;
    logic              wr_resume;
    logic              ram_we;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_rd_addr;
    logic [15:0]       ram_rd_data;

    assign pending     = (state_q != ST_IDLE);
    assign trans       = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~pending;
    assign wr_ctrl     = trans & wb_we_i & (wb_adr_i == OFF_DATA);
    assign wr_pause    = wr_ctrl & (wb_dat_i == CTRL_PAUSE);
    assign wr_resume   = wr_ctrl & (wb_dat_i != CTRL_PAUSE);
    assign ram_rd_addr = oldest_q + rd_idx_q[ADDR_W-1:0];

    assign wb_ack_o = (state_q == ST_RESP) & ~resp_err_q;
    assign wb_err_o = (state_q == ST_RESP) &  resp_err_q;
    assign wb_dat_o = dat_q;

    always_comb begin
        state_d    = state_q;
        paused_d   = paused_q;
        wp_d       = wp_q;
        count_d    = count_q;
        rd_idx_d   = rd_idx_q;
        oldest_d   = oldest_q;
        resp_err_d = resp_err_q;
        dat_d      = dat_q;
`ifdef VS_LOG_STATUS_EN
        dropped_d  = dropped_q;
`endif
        ram_we     = 1'b0;
        ram_re     = 1'b0;

        // A control write in the same cycle as a sample wins: resume discards it, pause counts it.
        if (wr_resume) begin
            paused_d  = 1'b0;
            wp_d      = '0;
            count_d   = '0;
`ifdef VS_LOG_STATUS_EN
            dropped_d = '0;
`endif
        end else begin
            if (wr_pause) begin
                paused_d = 1'b1;
                rd_idx_d = '0;
                oldest_d = wp_q - count_q[ADDR_W-1:0];
            end
            if (sample_valid && !paused_q && !wr_pause) begin
                ram_we = 1'b1;
                wp_d   = wp_q + 1'b1;
                if (count_q != FULL) begin
                    count_d = count_q + 1'b1;
                end
            end
`ifdef VS_LOG_STATUS_EN
            else if (sample_valid && dropped_q != 16'hffff) begin
                dropped_d = dropped_q + 16'd1;
            end
`endif
        end

        case (state_q)
            ST_IDLE: begin
                if (trans) begin
                    state_d    = ST_RESP;
                    resp_err_d = 1'b0;
                    if (wb_adr_i == OFF_DATA) begin
                        if (!wb_we_i) begin
                            if (!paused_q) begin
                                resp_err_d = 1'b1;
                            end else if (rd_idx_q != count_q) begin
                                state_d  = ST_RAM_WAIT;
                                ram_re   = 1'b1;
                                rd_idx_d = rd_idx_q + 1'b1;
                            end else begin
                                dat_d = END_MARK;
                            end
                        end
                    end
`ifdef VS_LOG_STATUS_EN
                    else if (!wb_we_i && wb_adr_i == OFF_LEVEL) begin
                        dat_d = 16'(count_q);
                    end else if (!wb_we_i && wb_adr_i == OFF_DROP) begin
                        dat_d = dropped_q;
                    end
`endif
                    else begin
                        resp_err_d = 1'b1;
                    end
                end
            end
            ST_RAM_WAIT: begin
                dat_d   = ram_rd_data;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= ST_IDLE;
            paused_q   <= 1'b0;
            wp_q       <= '0;
            count_q    <= '0;
            rd_idx_q   <= '0;
            oldest_q   <= '0;
            resp_err_q <= 1'b0;
            dat_q      <= '0;
`ifdef VS_LOG_STATUS_EN
            dropped_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            paused_q   <= paused_d;
            wp_q       <= wp_d;
            count_q    <= count_d;
            rd_idx_q   <= rd_idx_d;
            oldest_q   <= oldest_d;
            resp_err_q <= resp_err_d;
            dat_q      <= dat_d;
`ifdef VS_LOG_STATUS_EN
            dropped_q  <= dropped_d;
`endif
        end
    end

    vs_log_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (wb_clk_i),
        .wr_en   (ram_we),
        .wr_addr (wp_q),
        .wr_data (sample_data),
        .rd_en   (ram_re),
        .rd_addr (ram_rd_addr),
        .rd_data (ram_rd_data)
    );

endmodule

// File: tb/tb_vs_log_wb_slave.sv
// Self-checking bench for vs_log_wb_slave against a queue-based model of the sample log.
module tb_vs_log_wb_slave;

    localparam int DEPTH = 4096;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic        wb_we_i  = 1'b0;
    logic [1:0]  wb_adr_i = 2'd0;
    logic [15:0] wb_dat_i = 16'd0;
    logic [15:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        sample_valid = 1'b0;
    logic [15:0] sample_data  = 16'd0;

    vs_log_wb_slave dut (
        .wb_clk_i     (wb_clk_i),
        .wb_rst_i     (wb_rst_i),
        .wb_cyc_i     (wb_cyc_i),
        .wb_stb_i     (wb_stb_i),
        .wb_we_i      (wb_we_i),
        .wb_adr_i     (wb_adr_i),
        .wb_dat_i     (wb_dat_i),
        .wb_dat_o     (wb_dat_o),
        .wb_ack_o     (wb_ack_o),
        .wb_err_o     (wb_err_o),
        .sample_valid (sample_valid),
        .sample_data  (sample_data)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: log_q holds captured samples oldest-first.
    logic [15:0] log_q[$];
    bit          m_paused;
    int          m_dropped;
    int          m_rd;
    bit          m_resume_now;
    bit          exp_ack, exp_err, exp_chk_dat;
    int          exp_lat;
    logic [15:0] exp_dat;

    function automatic void model_reset();
        log_q.delete();
        m_paused     = 1'b0;
        m_dropped    = 0;
        m_rd         = 0;
        m_resume_now = 1'b0;
    endfunction

    function automatic void model_trans(bit we, logic [1:0] adr, logic [15:0] wd);
        exp_ack     = 1'b1;
        exp_err     = 1'b0;
        exp_lat     = 1;
        exp_chk_dat = 1'b0;
        exp_dat     = 16'd0;
        if (adr == 2'd0) begin
            if (we) begin
                if (wd == 16'd0) begin
                    m_paused = 1'b1;
                    m_rd     = 0;
                end else begin
                    m_resume_now = 1'b1;
                    m_paused     = 1'b0;
                    log_q.delete();
                    m_dropped    = 0;
                end
            end else if (!m_paused) begin
                exp_ack = 1'b0;
                exp_err = 1'b1;
            end else if (m_rd < log_q.size()) begin
                exp_dat     = log_q[m_rd];
                exp_chk_dat = 1'b1;
                exp_lat     = 2;
                m_rd++;
            end else begin
                exp_dat     = 16'hffff;
                exp_chk_dat = 1'b1;
            end
        end
`ifdef VS_LOG_STATUS_EN
        else if (!we && adr == 2'd1) begin
            exp_dat     = 16'(log_q.size());
            exp_chk_dat = 1'b1;
        end else if (!we && adr == 2'd2) begin
            exp_dat     = 16'(m_dropped);
            exp_chk_dat = 1'b1;
        end
`endif
        else begin
            exp_ack = 1'b0;
            exp_err = 1'b1;
        end
    endfunction

    function automatic void model_sample(bit sv, logic [15:0] sd);
        if (sv && !m_resume_now) begin
            if (m_paused) begin
                if (m_dropped < 65535) m_dropped++;
            end else begin
                log_q.push_back(sd);
                if (log_q.size() > DEPTH) void'(log_q.pop_front());
            end
        end
        m_resume_now = 1'b0;
    endfunction

    task automatic tick(input bit sv, input logic [15:0] sd);
        sample_valid = sv;
        sample_data  = sd;
        @(posedge wb_clk_i); #1;
        model_sample(sv, sd);
        sample_valid = 1'b0;
    endtask

    task automatic tick_rand();
        tick(1'($urandom_range(0, 1)), 16'($urandom));
    endtask

    task automatic run_op(input bit we, input logic [1:0] adr, input logic [15:0] wd,
                          input bit rnd, output logic [15:0] rd);
        int          lat;
        bit          done;
        bit          sv;
        logic [15:0] sd;
        bit          got_ack, got_err;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_dat_i = wd;
        lat  = 0;
        done = 1'b0;
        while (!done) begin
            sv = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
            sd = 16'($urandom);
            sample_valid = sv;
            sample_data  = sd;
            @(posedge wb_clk_i); #1;
            if (lat == 0) model_trans(we, adr, wd);
            model_sample(sv, sd);
            lat++;
            if (wb_ack_o || wb_err_o || lat >= 8) done = 1'b1;
        end
        got_ack = wb_ack_o;
        got_err = wb_err_o;
        rd      = wb_dat_o;
        wb_cyc_i     = 1'b0;
        wb_stb_i     = 1'b0;
        sample_valid = 1'b0;
        check_eq("ack", 32'(got_ack), 32'(exp_ack));
        check_eq("err", 32'(got_err), 32'(exp_err));
        check_eq("latency", 32'(lat), 32'(exp_lat));
        if (exp_chk_dat) check_eq("rdata", 32'(rd), 32'(exp_dat));
        if (rnd) tick_rand(); else tick(1'b0, 16'd0);
        check_eq("resp_1cyc", 32'({wb_ack_o, wb_err_o}), 32'd0);
    endtask

    logic [15:0] rd;
    logic [15:0] first_val;

    initial begin
        #50_000_000;
        $display("FAIL watchdog simulation did not finish t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        wb_rst_i = 1'b1;
        repeat (3) @(posedge wb_clk_i);
        #1;
        check_eq("rst_ack", 32'(wb_ack_o), 32'd0);
        check_eq("rst_err", 32'(wb_err_o), 32'd0);
        check_eq("rst_dat", 32'(wb_dat_o), 32'd0);
        wb_rst_i = 1'b0;
        tick(1'b0, 16'd0);

        // Short log: 10 samples, then end mark.
        for (int v = 0; v < 10; v++) tick(1'b1, 16'(v));
        run_op(1'b1, 2'd0, 16'h0000, 1'b0, rd);
        for (int i = 0; i < 11; i++) run_op(1'b0, 2'd0, 16'h0, 1'b0, rd);
        check_eq("end_mark", 32'(rd), 32'hffff);

        // Wrap-around: 4100 samples into a 4096-entry log.
        run_op(1'b1, 2'd0, 16'h0001, 1'b0, rd);
        for (int v = 0; v < 4100; v++) tick(1'b1, 16'(v));
        run_op(1'b1, 2'd0, 16'h0000, 1'b0, rd);
        run_op(1'b0, 2'd1, 16'h0, 1'b0, rd);
        for (int i = 0; i < DEPTH; i++) begin
            run_op(1'b0, 2'd0, 16'h0, 1'b0, rd);
            if (i == 0) check_eq("wrap_first", 32'(rd), 32'd4);
            if (i == DEPTH - 1) check_eq("wrap_last", 32'(rd), 32'd4099);
        end
        run_op(1'b0, 2'd0, 16'h0, 1'b0, rd);
        check_eq("wrap_end", 32'(rd), 32'hffff);

        // Dropped samples while paused, then clear by resume.
        for (int i = 0; i < 3; i++) tick(1'b1, 16'(100 + i));
        run_op(1'b0, 2'd2, 16'h0, 1'b0, rd);
        run_op(1'b1, 2'd0, 16'h0001, 1'b0, rd);
        run_op(1'b0, 2'd2, 16'h0, 1'b0, rd);
        run_op(1'b0, 2'd1, 16'h0, 1'b0, rd);

        // Error responses.
        run_op(1'b0, 2'd0, 16'h0, 1'b0, rd);
        run_op(1'b1, 2'd3, 16'h1234, 1'b0, rd);
        run_op(1'b1, 2'd1, 16'h0005, 1'b0, rd);
        run_op(1'b0, 2'd3, 16'h0, 1'b0, rd);

        // Rewind: read part of the log, pause again, oldest comes back.
        first_val = 16'($urandom);
        tick(1'b1, first_val);
        for (int i = 0; i < 19; i++) tick(1'b1, 16'($urandom));
        run_op(1'b1, 2'd0, 16'h0000, 1'b0, rd);
        for (int i = 0; i < 5; i++) run_op(1'b0, 2'd0, 16'h0, 1'b0, rd);
        run_op(1'b1, 2'd0, 16'h0000, 1'b0, rd);
        run_op(1'b0, 2'd0, 16'h0, 1'b0, rd);
        check_eq("rewind", 32'(rd), 32'(first_val));

        // Reset asserted while a data read is in RAM_WAIT.
        run_op(1'b1, 2'd0, 16'h0001, 1'b0, rd);
        for (int i = 0; i < 5; i++) tick(1'b1, 16'(i + 7));
        run_op(1'b1, 2'd0, 16'h0000, 1'b0, rd);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b0;
        wb_adr_i = 2'd0;
        @(posedge wb_clk_i); #1;
        check_eq("rstmid_pend", 32'({wb_ack_o, wb_err_o}), 32'd0);
        wb_rst_i = 1'b1;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        @(posedge wb_clk_i); #1;
        check_eq("rstmid_noresp", 32'({wb_ack_o, wb_err_o}), 32'd0);
        check_eq("rstmid_dat", 32'(wb_dat_o), 32'd0);
        wb_rst_i = 1'b0;
        model_reset();
        tick(1'b0, 16'd0);
        run_op(1'b0, 2'd1, 16'h0, 1'b0, rd);
        run_op(1'b0, 2'd0, 16'h0, 1'b0, rd);

        // Randomized traffic with concurrent samples.
        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 2) begin
                repeat ($urandom_range(1, 4)) tick_rand();
            end else if (r < 5) begin
                run_op(1'b0, 2'd0, 16'h0, 1'b1, rd);
            end else if (r == 5) begin
                run_op(1'b1, 2'd0, 16'h0000, 1'b1, rd);
            end else if (r == 6) begin
                run_op(1'b1, 2'd0, 16'($urandom_range(1, 65535)), 1'b1, rd);
            end else begin
                run_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom), 1'b1, rd);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vs_log_wb_slave.md
Name: vs_log_wb_slave

Overview:
- Wishbone slave holding a circular log of 16-bit voltage-sequencer samples, read out through one indirect data register.
- Sits on the monitor Wishbone bus at VS_INDIRECT_A and is the responder to dma_engine's crash-dump transfer into flash.
- A control write of 0 freezes capture and rewinds the read index. Each following data read returns the next-oldest sample, then 16'hffff once the log is exhausted.

Parameters:
- ADDR_W, 12: log depth is 2^ADDR_W entries (4096).
- END_MARK, 16'hffff: value returned past the last valid entry.

Ports:
- wb_clk_i  in  1  Wishbone clock; sole clock.
- wb_rst_i  in  1  Reset; synchronous, active-high.
- wb_cyc_i  in  1  Wishbone cycle.
- wb_stb_i  in  1  Wishbone strobe.
- wb_we_i  in  1  Write enable.
- wb_adr_i  in  2  Register offset: 0 = data/control, 1 = level, 2 = dropped count.
- wb_dat_i  in  16  Write data.
- wb_dat_o  out  16  Read data; valid while wb_ack_o is high.
- wb_ack_o  out  1  Single-cycle acknowledge.
- wb_err_o  out  1  Single-cycle error.
- sample_valid  in  1  Producer strobe.
- sample_data  in  16  Producer sample.

Behaviour:
- Reset values:
  - wb_ack_o=0, wb_err_o=0, wb_dat_o=0.
  - paused=0 (capturing), wp=0, count=0, rd_idx=0, dropped=0.
  - RAM contents undefined.
- Capture (paused=0):
  - On sample_valid, write sample_data to mem[wp]; wp increments modulo 2^ADDR_W.
  - count saturates at 2^ADDR_W. Once full, the oldest entry is overwritten.
- Paused:
  - sample_valid is dropped.
  - dropped increments and saturates at 16'hffff.
- Transaction start: trans = cyc & stb & ~ack_o & ~pending. The slave ignores stb in the ack/err cycle.
- Write to offset 0, data==0:
  - paused<=1, rd_idx<=0, oldest<=wp-count (mod depth), latched in the same cycle.
  - Ack on the next cycle.
- Write to offset 0, data!=0:
  - paused<=0, wp<=0, count<=0, dropped<=0 (log cleared).
  - Ack on the next cycle.
- Read offset 0 while paused:
  - rd_idx<count: RAM read of mem[oldest+rd_idx]; rd_idx increments. Ack 2 cycles after trans (address reg, RAM output). wb_dat_o holds the sample.
  - rd_idx==count: wb_dat_o=END_MARK, ack after 1 cycle, rd_idx unchanged. Repeated reads keep returning END_MARK.
- Read offset 0 while not paused: wb_err_o after 1 cycle, no state change.
- Read offset 1: ack after 1 cycle, wb_dat_o = count (zero-extended; 2^ADDR_W reads as 16'h1000).
- Read offset 2: ack after 1 cycle, wb_dat_o = dropped.
- Writes to offsets 1, 2 and any access to offset 3: wb_err_o after 1 cycle, no effect.
- FSM: IDLE, RAM_WAIT (offset-0 data read, 1 cycle), RESP (drive ack/err for 1 cycle), then back to IDLE. pending=1 in RAM_WAIT and RESP.
- Simultaneous events:
  - sample_valid in the same cycle as a pause write: the sample is dropped and counted. The pause takes precedence.
  - sample_valid in the same cycle as a resume write: the sample is not stored and not counted. The log restarts empty.
- Master drops cyc mid-RAM_WAIT: the response is still issued for 1 cycle and rd_idx has already advanced. The master must tolerate the stray ack.
- wb_rst_i at any point returns everything to reset values, including mid-transaction. No ack is issued.

Optional Feature:
- VS_LOG_STATUS_EN:
  - Defined: offsets 1 and 2 and the dropped counter are implemented as above.
  - Undefined: the dropped counter is removed, and any access to offsets 1–3 returns wb_err_o.

Decomposition:
- Package vs_log_pkg holds:
  - offset constants OFF_DATA=0, OFF_LEVEL=1, OFF_DROP=2;
  - END_MARK default;
  - CTRL_PAUSE=16'h0000;
  - FSM state encoding.
- One sub-module, vs_log_ram: simple dual-port RAM, 2^ADDR_W x 16, synchronous write port (capture) and registered read port (Wishbone).

Test Plan:
- Reset; push samples 0..9; write 0 to offset 0; 11 reads at offset 0 -> data 0..9 with 2-cycle ack latency, then 16'hffff with 1-cycle latency.
- Push 4100 samples valued 0..4099 (wraps); pause; read offset 1 -> 16'h1000; first data read -> 4; 4096th read -> 4099; next read -> 16'hffff.
- Pause; pulse sample_valid 3 times; read offset 2 -> 3; write 16'h0001 to offset 0; read offset 2 -> 0 and offset 1 -> 0.
- Read offset 0 while capturing -> wb_err_o=1 for 1 cycle, wb_ack_o=0. Write to offset 3 -> wb_err_o.
- Pause; read 5 entries; write 0 again -> rd_idx rewinds, next read returns the oldest entry again. Assert wb_rst_i during RAM_WAIT -> no ack, offset 1 reads 0 afterwards.
- Without VS_LOG_STATUS_EN: read offset 1 -> wb_err_o; offset 0 data path unchanged.
